microcode_sequencer: RTL and testbench

//  Parametrised microcode store plus sequencer. Owns the opcode register, micro-op counter and

---
 rtl/microcode_sequencer_pkg.sv | 17 +
 rtl/microcode_boot_loader.sv | 69 ++++++
 rtl/microcode_sequencer.sv | 93 +++++++++
 tb/tb_microcode_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer and its consumers (control_logic).
package microcode_sequencer_pkg;

  typedef enum logic {
    McseqBoot,
    McseqRun
  } mcseq_state_e;

  // Well-known opcodes: the reset opcode is presented on the first run cycle.
  localparam int unsigned OpReset = 0;
  localparam int unsigned OpFetch = 1;

  function automatic int unsigned calc_idx_bits(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/microcode_boot_loader.sv
// Bootstrap loader: assembles bytes into control words and walks the store address once.
module microcode_boot_loader
  import microcode_sequencer_pkg::*;
#(
  parameter int unsigned AddrBits = 12,
  parameter int unsigned Width    = 32
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [7:0]          boot_data,
  input  logic                boot_valid,
  output logic                boot_ready,
  output logic                n_booted,
  output logic                wr_en,
  output logic [AddrBits-1:0] wr_addr,
  output logic [Width-1:0]    wr_data
);

  localparam int unsigned NBytes  = Width / 8;
  localparam int unsigned IdxBits = calc_idx_bits(NBytes);

  mcseq_state_e        state_q, state_d;
  logic [IdxBits-1:0]  idx_q, idx_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [Width-1:0]    word_q, word_d;
  logic                accept, last_byte;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= McseqBoot;
      idx_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    word_d    = word_q;
    accept    = (state_q == McseqBoot) && boot_valid;
    last_byte = (idx_q == IdxBits'(NBytes - 1));
    wr_en     = accept && last_byte;
    wr_addr   = addr_q;
    // The final byte bypasses the buffer so the word is written on the edge it arrives.
    wr_data   = word_q;
    wr_data[Width-1 -: 8] = boot_data;
    if (accept) begin
      if (last_byte) begin
        idx_d  = '0;
        addr_d = addr_q + 1'b1;
        if (&addr_q) state_d = McseqRun;
      end else begin
        idx_d = idx_q + 1'b1;
        word_d[{idx_q, 3'b000} +: 8] = boot_data;
      end
    end
  end

  assign n_booted   = (state_q == McseqBoot);
  assign boot_ready = (state_q == McseqBoot);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode store plus sequencer: forms {cond, opcode, uop} and reads the control word.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int unsigned OPCODE_BITS = 6,
  parameter int unsigned UOP_BITS    = 5,
  parameter int unsigned WIDTH       = 32,
  localparam int unsigned ADDR_BITS  = 1 + OPCODE_BITS + UOP_BITS
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [7:0]             boot_data,
  input  logic                   boot_valid,
  output logic                   boot_ready,
  output logic                   n_booted,
  input  logic                   stall,
  input  logic                   cond_in,
  input  logic [OPCODE_BITS-1:0] opcode_in,
  input  logic                   load_opcode,
  input  logic                   reset_uop,
  output logic [ADDR_BITS-1:0]   addr,
  output logic [WIDTH-1:0]       out,
  output logic                   uop_overflow
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic                   wr_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [WIDTH-1:0]       wr_data;

  logic [WIDTH-1:0]       store_q [Depth];
  logic                   cond_q, cond_d;
  logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
  logic [UOP_BITS-1:0]    uop_q, uop_d;
  logic                   ovf_q, ovf_d;

  microcode_boot_loader #(
    .AddrBits (ADDR_BITS),
    .Width    (WIDTH)
  ) u_boot_loader (
    .clk        (clk),
    .n_rst      (n_rst),
    .boot_data  (boot_data),
    .boot_valid (boot_valid),
    .boot_ready (boot_ready),
    .n_booted   (n_booted),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Store contents deliberately survive reset; the loader rewrites every word anyway.
  always_ff @(posedge clk) begin
    if (wr_en) store_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cond_q   <= 1'b0;
      opcode_q <= OPCODE_BITS'(OpReset);
      uop_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cond_q   <= cond_d;
      opcode_q <= opcode_d;
      uop_q    <= uop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    cond_d   = cond_q;
    opcode_d = opcode_q;
    uop_d    = uop_q;
    ovf_d    = ovf_q;
    if (!n_booted && !stall) begin
      cond_d = cond_in;
      if (reset_uop) begin
        uop_d = '0;
      end else begin
        uop_d = uop_q + 1'b1;
        if (&uop_q) ovf_d = 1'b1;
      end
      if (load_opcode) opcode_d = opcode_in;
    end
  end

  assign addr         = {cond_q, opcode_q, uop_q};
  assign out          = n_booted ? '0 : store_q[addr];
  assign uop_overflow = ovf_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomised bench for microcode_sequencer against a behavioural address/store model.
module tb_microcode_sequencer;

  localparam int unsigned OB = 2;
  localparam int unsigned UB = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned AB = 1 + OB + UB;
  localparam int unsigned NW = 1 << AB;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    boot_data = '0;
  logic          boot_valid = 1'b0;
  logic          boot_ready, n_booted;
  logic          stall = 1'b0, cond_in = 1'b0, load_opcode = 1'b0, reset_uop = 1'b0;
  logic [OB-1:0] opcode_in = '0;
  logic [AB-1:0] addr;
  logic [W-1:0]  out;
  logic          uop_overflow;

  always #5 clk = ~clk;

  microcode_sequencer #(
    .OPCODE_BITS (OB),
    .UOP_BITS    (UB),
    .WIDTH       (W)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .boot_data    (boot_data),
    .boot_valid   (boot_valid),
    .boot_ready   (boot_ready),
    .n_booted     (n_booted),
    .stall        (stall),
    .cond_in      (cond_in),
    .opcode_in    (opcode_in),
    .load_opcode  (load_opcode),
    .reset_uop    (reset_uop),
    .addr         (addr),
    .out          (out),
    .uop_overflow (uop_overflow)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model: store image plus the three sequencer fields as plain integers.
  logic [31:0] mem_m [NW];
  int          m_cond = 0, m_opc = 0, m_uop = 0;
  int          m_ovf = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr();
    return m_cond * 16 + m_opc * 4 + m_uop;
  endfunction

  task automatic noise();
    stall       = 1'($urandom_range(1));
    cond_in     = 1'($urandom_range(1));
    load_opcode = 1'($urandom_range(1));
    reset_uop   = 1'($urandom_range(1));
    opcode_in   = OB'($urandom_range(3));
  endtask

  task automatic check_boot_idle(input string tag);
    check_eq({tag, "_n_booted"}, 64'(n_booted), 64'd1);
    check_eq({tag, "_ready"}, 64'(boot_ready), 64'd1);
    check_eq({tag, "_addr"}, 64'(addr), 64'd0);
    check_eq({tag, "_out"}, 64'(out), 64'd0);
  endtask

  task automatic boot_byte(input logic [7:0] b);
    while ($urandom_range(3) == 0) begin
      @(negedge clk);
      check_boot_idle("boot_gap");
      boot_valid = 1'b0;
      boot_data  = 8'($urandom);
      noise();
      @(posedge clk);
    end
    @(negedge clk);
    check_boot_idle("boot_byte");
    boot_valid = 1'b1;
    boot_data  = b;
    noise();
    @(posedge clk);
  endtask

  // Drive one run-mode cycle from a negedge, advance the model, return on the next negedge.
  task automatic step(input int s, input int c, input int opc, input int ld, input int ru);
    stall       = (s != 0);
    cond_in     = (c != 0);
    opcode_in   = OB'(opc);
    load_opcode = (ld != 0);
    reset_uop   = (ru != 0);
    if (s == 0) begin
      m_cond = (c != 0) ? 1 : 0;
      if (ru != 0) begin
        m_uop = 0;
      end else begin
        if (m_uop == 3) m_ovf = 1;
        m_uop = (m_uop + 1) % 4;
      end
      if (ld != 0) m_opc = opc % 4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_run(input string tag);
    check_eq({tag, "_addr"}, 64'(addr), 64'(exp_addr()));
    check_eq({tag, "_out"}, 64'(out), 64'(mem_m[exp_addr()]));
    check_eq({tag, "_ovf"}, 64'(uop_overflow), 64'(m_ovf));
    check_eq({tag, "_n_booted"}, 64'(n_booted), 64'd0);
  endtask

  initial begin
    #12;
    check_eq("rst_n_booted", 64'(n_booted), 64'd1);
    check_eq("rst_ready", 64'(boot_ready), 64'd1);
    check_eq("rst_addr", 64'(addr), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_ovf", 64'(uop_overflow), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Partial first pass with junk data, then reset mid-boot.
    for (int i = 0; i < 50; i++) boot_byte(8'($urandom));
    @(negedge clk);
    boot_valid = 1'b0;
    n_rst      = 1'b0;
    #1;
    check_boot_idle("midboot_rst");
    @(negedge clk);
    n_rst = 1'b1;

    for (int k = 0; k < int'(NW); k++) begin
      mem_m[k] = 32'hA500_0000 | 32'(k);
      for (int b = 0; b < 4; b++) boot_byte(8'(mem_m[k] >> (8 * b)));
    end
    @(negedge clk);
    boot_valid = 1'b0;
    stall = 1'b0; cond_in = 1'b0; load_opcode = 1'b0; reset_uop = 1'b0; opcode_in = '0;
    check_eq("booted_ready", 64'(boot_ready), 64'd0);
    check_eq("first_run_out", 64'(out), 64'hA500_0000);
    check_run("first_run");

    // Free-running uop counter wraps and sets the sticky overflow.
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0);
      check_eq("idle_addr", 64'(addr), 64'(i % 4));
      check_eq("idle_ovf", 64'(uop_overflow), 64'(i == 4));
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 1);
    check_eq("fetch_handoff", 64'(addr), 64'd8);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    check_eq("opc1_uop1", 64'(addr), 64'd5);
    step(0, 1, 0, 0, 0);
    check_eq("cond_addr", 64'(addr), 64'd22);
    check_eq("cond_out", 64'(out), 64'hA500_0016);
    step(1, 0, 3, 1, 1);
    check_eq("stall_hold", 64'(addr), 64'd22);
    check_run("stall_model");

    // Read back every store word through the sequencer.
    for (int a = 0; a < int'(NW); a++) begin
      step(0, a >> 4, (a >> 2) & 3, 1, 1);
      for (int j = 0; j < (a & 3); j++) step(0, a >> 4, 0, 0, 0);
      check_eq("readback_addr", 64'(addr), 64'(a));
      check_eq("readback_out", 64'(out), 64'(32'hA500_0000 | 32'(a)));
    end

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3) == 0) ? 1 : 0, int'($urandom_range(1)), int'($urandom_range(3)),
           int'($urandom_range(1)), ($urandom_range(2) == 0) ? 1 : 0);
      check_run("rand");
    end

    n_rst = 1'b0;
    #1;
    check_eq("midrun_rst_n_booted", 64'(n_booted), 64'd1);
    check_eq("midrun_rst_addr", 64'(addr), 64'd0);
    check_eq("midrun_rst_out", 64'(out), 64'd0);
    check_eq("midrun_rst_ovf", 64'(uop_overflow), 64'd0);
    check_eq("midrun_rst_ready", 64'(boot_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
